// File: rtl/atconv_pkg.sv
// Shared types and arithmetic helpers for the dilated-conv + max-pool engine.
package atconv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV_RD,
        CONV_CALC,
        CONV_WR,
        POOL_RD,
        POOL_WR,
        DONE
    } state_t;

    // Tap issue order: TL,T,TR,L,C,R,BL,B,BR
    localparam logic [3:0] TAP_TL = 4'd0;
    localparam logic [3:0] TAP_T  = 4'd1;
    localparam logic [3:0] TAP_TR = 4'd2;
    localparam logic [3:0] TAP_L  = 4'd3;
    localparam logic [3:0] TAP_C  = 4'd4;
    localparam logic [3:0] TAP_R  = 4'd5;
    localparam logic [3:0] TAP_BL = 4'd6;
    localparam logic [3:0] TAP_B  = 4'd7;
    localparam logic [3:0] TAP_BR = 4'd8;

    localparam logic [3:0] CONV_LAST_STEP = 4'd9;
    localparam logic [3:0] POOL_LAST_STEP = 4'd4;

    // ReLU followed by clamp to the largest positive dw-bit value
    function automatic logic [31:0] relu_sat(input logic signed [31:0] acc, input int dw);
        logic signed [31:0] top;
        top = (32'sd1 <<< (dw - 1)) - 32'sd1;
        if (acc < 32'sd0)
            return 32'd0;
        if (acc > top)
            return top;
        return acc;
    endfunction

    // Round a non-negative fixed-point value up to the next integer, clamped to the largest integer
    function automatic logic [31:0] ceil_round(input logic [31:0] v, input int dw, input int frac);
        logic [31:0] mask;
        logic [31:0] top;
        logic [31:0] up;
        mask = (32'd1 << frac) - 32'd1;
        top  = ((32'd1 << (dw - 1)) - 32'd1) & ~mask;
        if ((v & mask) == 32'd0)
            return v;
        up = (v & ~mask) + (32'd1 << frac);
        return (up > top) ? top : up;
    endfunction

endpackage

// File: rtl/atconv_tap_gen.sv
// Combinational tap address generator: dilated offset, clamp to image, zero-pad mask.
module atconv_tap_gen
    import atconv_pkg::*;
#(
    parameter  int IMG_W = 64,
    parameter  int DIL   = 2,
    localparam int LW    = $clog2(IMG_W),
    localparam int AW    = 2 * LW
) (
    input  logic [LW-1:0] r,
    input  logic [LW-1:0] c,
    input  logic [3:0]    tap,
    input  logic          pad_mode,
    output logic [AW-1:0] addr,
    output logic          zero_mask
);

    localparam int DIL_I = DIL;
    localparam int MAX_I = IMG_W - 1;
    localparam logic signed [LW+1:0] DIL_S = DIL_I[LW+1:0];
    localparam logic signed [LW+1:0] MAX_S = MAX_I[LW+1:0];

    logic signed [LW+1:0] off   [2];
    logic signed [LW+1:0] coord [2];
    logic        [LW-1:0] clamped [2];
    logic                 oob   [2];

    always_comb begin
        off[0] = '0;
        off[1] = '0;
        case (tap)
            TAP_TL, TAP_T, TAP_TR: off[0] = -DIL_S;
            TAP_BL, TAP_B, TAP_BR: off[0] = DIL_S;
            default: ;
        endcase
        case (tap)
            TAP_TL, TAP_L, TAP_BL: off[1] = -DIL_S;
            TAP_TR, TAP_R, TAP_BR: off[1] = DIL_S;
            default: ;
        endcase
    end

    assign coord[0] = $signed({2'b00, r}) + off[0];
    assign coord[1] = $signed({2'b00, c}) + off[1];

    // Index 0 is the row axis, index 1 the column axis
    for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
        assign oob[gi]     = (coord[gi] < 0) || (coord[gi] > MAX_S);
        assign clamped[gi] = (coord[gi] < 0)     ? '0 :
                             (coord[gi] > MAX_S) ? MAX_S[LW-1:0] :
                                                   coord[gi][LW-1:0];
    end

    assign addr      = {clamped[0], clamped[1]};
    assign zero_mask = pad_mode & (oob[0] | oob[1]);

endmodule

// File: rtl/atconv_pool_p.sv
// Dilated 3x3 high-pass conv (bias, ReLU, saturate) into layer0, then 2x2 ceil max-pool into layer1.
// Optional ATCONV_PERF_EN adds a busy-cycle counter output cycle_cnt.
module atconv_pool_p
    import atconv_pkg::*;
#(
    parameter  int IMG_W = 64,
    parameter  int DW    = 13,
    parameter  int FRAC  = 4,
    parameter  int DIL   = 2,
    parameter  int BIAS  = 12,
    localparam int LW    = $clog2(IMG_W),
    localparam int AW    = 2 * LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic          pad_mode,
    output logic          busy,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          csel
`ifdef ATCONV_PERF_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    localparam int ACC_W = DW + 4;
    localparam int PW    = LW - 1;
    localparam logic [LW-1:0] PIX_MAX  = '1;
    localparam logic [PW-1:0] POOL_MAX = '1;

    state_t state_reg, state_next;
    logic                    pad_reg, busy_reg, busy_next, mask_d_reg, start;
    logic [LW-1:0]           r_reg, r_next, c_reg, c_next;
    logic [3:0]              step_reg, step_next, tap_d;
    logic signed [ACC_W-1:0] acc_reg, acc_next, tap_val, contrib;
    logic [DW-1:0]           max_reg, max_next, rd_max, cdata_wr_reg;
    logic                    cwr_reg, csel_reg;
    logic [AW-1:0]           caddr_wr_reg, iaddr_hold_reg, caddr_rd_hold_reg;
    logic [AW-1:0]           tap_addr, pool_rd_addr;
    logic                    tap_zero;

    atconv_tap_gen #(.IMG_W(IMG_W), .DIL(DIL)) u_tap_gen (
        .r         (r_reg),
        .c         (c_reg),
        .tap       (step_reg),
        .pad_mode  (pad_reg),
        .addr      (tap_addr),
        .zero_mask (tap_zero)
    );

    assign start = (state_reg == IDLE) && ready && !busy_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start) state_next = CONV_RD;
            CONV_RD:   if (step_reg == CONV_LAST_STEP) state_next = CONV_CALC;
            CONV_CALC: state_next = CONV_WR;
            CONV_WR:   state_next = (r_reg == PIX_MAX && c_reg == PIX_MAX) ? POOL_RD : CONV_RD;
            POOL_RD:   if (step_reg == POOL_LAST_STEP) state_next = POOL_WR;
            POOL_WR:   state_next = (r_reg[PW-1:0] == POOL_MAX && c_reg[PW-1:0] == POOL_MAX) ? DONE : POOL_RD;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // busy stays up through DONE and the first IDLE cycle; that IDLE cycle also masks ready
    always_comb begin
        busy_next = 1'b1;
        if (state_reg == IDLE)
            busy_next = start;

        step_next = 4'd0;
        if ((state_reg == CONV_RD || state_reg == POOL_RD) && state_next == state_reg)
            step_next = step_reg + 4'd1;

        r_next = r_reg;
        c_next = c_reg;
        if (start) begin
            r_next = '0;
            c_next = '0;
        end else if (state_reg == CONV_WR) begin
            c_next = c_reg + LW'(1);
            if (c_reg == PIX_MAX)
                r_next = r_reg + LW'(1);
        end else if (state_reg == POOL_WR) begin
            if (c_reg[PW-1:0] == POOL_MAX) begin
                c_next = '0;
                r_next = (r_reg[PW-1:0] == POOL_MAX) ? '0 : r_reg + LW'(1);
            end else begin
                c_next = c_reg + LW'(1);
            end
        end
    end

    // Each tap's data arrives one step after its address, so it is weighted by the previous index
    always_comb begin
        tap_d   = step_reg - 4'd1;
        tap_val = mask_d_reg ? '0 : ACC_W'($signed(idata));
        case (tap_d)
            TAP_TL, TAP_TR, TAP_BL, TAP_BR: contrib = -(tap_val >>> 4);
            TAP_T, TAP_B:                   contrib = -(tap_val >>> 3);
            TAP_L, TAP_R:                   contrib = -(tap_val >>> 2);
            TAP_C:                          contrib = tap_val;
            default:                        contrib = '0;
        endcase
        acc_next = acc_reg;
        if (state_reg == CONV_RD)
            acc_next = (step_reg == 4'd0) ? '0 : acc_reg + contrib;

        rd_max   = (cdata_rd > max_reg) ? cdata_rd : max_reg;
        max_next = max_reg;
        if (state_reg == POOL_RD) begin
            if (step_reg == 4'd1)
                max_next = cdata_rd;
            else if (step_reg > 4'd1)
                max_next = rd_max;
        end
    end

    assign pool_rd_addr = {r_reg[PW-1:0], step_reg[1], c_reg[PW-1:0], step_reg[0]};
    assign iaddr    = (state_reg == CONV_RD && step_reg < CONV_LAST_STEP) ? tap_addr : iaddr_hold_reg;
    assign crd      = (state_reg == POOL_RD && step_reg < POOL_LAST_STEP);
    assign caddr_rd = crd ? pool_rd_addr : caddr_rd_hold_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            busy_reg          <= 1'b0;
            pad_reg           <= 1'b0;
            step_reg          <= '0;
            r_reg             <= '0;
            c_reg             <= '0;
            acc_reg           <= '0;
            max_reg           <= '0;
            mask_d_reg        <= 1'b0;
            iaddr_hold_reg    <= '0;
            caddr_rd_hold_reg <= '0;
            cwr_reg           <= 1'b0;
            csel_reg          <= 1'b0;
            caddr_wr_reg      <= '0;
            cdata_wr_reg      <= '0;
        end else begin
            state_reg         <= state_next;
            busy_reg          <= busy_next;
            step_reg          <= step_next;
            r_reg             <= r_next;
            c_reg             <= c_next;
            acc_reg           <= acc_next;
            max_reg           <= max_next;
            mask_d_reg        <= tap_zero;
            iaddr_hold_reg    <= iaddr;
            caddr_rd_hold_reg <= caddr_rd;
            if (start)
                pad_reg <= pad_mode;
            // Write strobe, address and data are registered one cycle ahead of the write state
            if (state_next == CONV_WR) begin
                cwr_reg      <= 1'b1;
                csel_reg     <= 1'b0;
                caddr_wr_reg <= {r_reg, c_reg};
                cdata_wr_reg <= DW'(relu_sat(32'(acc_reg) - 32'(BIAS), DW));
            end else if (state_next == POOL_WR) begin
                cwr_reg      <= 1'b1;
                csel_reg     <= 1'b1;
                caddr_wr_reg <= AW'({r_reg[PW-1:0], c_reg[PW-1:0]});
                cdata_wr_reg <= DW'(ceil_round(32'(rd_max), DW, FRAC));
            end else begin
                cwr_reg <= 1'b0;
                if (state_next == POOL_RD)
                    csel_reg <= 1'b0;
            end
        end
    end

`ifdef ATCONV_PERF_EN
    logic [31:0] cycle_cnt_reg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cycle_cnt_reg <= '0;
        else if (start)
            cycle_cnt_reg <= '0;
        else if (busy_reg)
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
    assign cycle_cnt = cycle_cnt_reg;
`endif

    assign busy     = busy_reg;
    assign cwr      = cwr_reg;
    assign csel     = csel_reg;
    assign caddr_wr = caddr_wr_reg;
    assign cdata_wr = cdata_wr_reg;

endmodule

// File: tb/tb_atconv_pool_p.sv
// Scoreboard bench for atconv_pool_p on a 16x16 image, DIL=2: expected writes queued per job, monitor compares.
module tb_atconv_pool_p;

    localparam int IMG_W    = 16;
    localparam int NPIX     = IMG_W * IMG_W;
    localparam int NPOOL    = NPIX / 4;
    localparam int EXP_BUSY = NPIX * 12 + NPOOL * 6 + 2;

    typedef struct packed {
        logic        sel;
        logic [7:0]  addr;
        logic [12:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, ready, pad_mode;
    logic        busy, cwr, crd, csel;
    logic [7:0]  iaddr, caddr_wr, caddr_rd;
    logic [12:0] idata, cdata_wr, cdata_rd;
`ifdef ATCONV_PERF_EN
    logic [31:0] cycle_cnt;
`endif

    logic [12:0] img [NPIX];
    logic [12:0] l0  [NPIX];
    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr = 0;
    int          busy_cnt = 0;
    logic        busy_prev = 1'b0;
    logic        abort_flag = 1'b0;
    int          job_no = 0;

    atconv_pool_p #(.IMG_W(IMG_W), .DW(13), .FRAC(4), .DIL(2), .BIAS(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .pad_mode (pad_mode),
        .busy     (busy),
        .iaddr    (iaddr),
        .idata    (idata),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .csel     (csel)
`ifdef ATCONV_PERF_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Image ROM and layer0 RAM with one-cycle registered reads
    always @(posedge clk) begin
        idata <= img[iaddr];
        if (cwr && !csel)
            l0[caddr_wr] <= cdata_wr;
        if (crd)
            cdata_rd <= l0[caddr_rd];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per write strobe and measures busy width
    always @(negedge clk) begin
        exp_t e;
        if (cwr) begin
            n_wr++;
            if (crd)
                chk("cwr_crd_overlap", 32'(crd), 32'd0);
            if (exp_q.size() == 0) begin
                chk($sformatf("unexpected_wr sel=%0d addr=%0d", csel, caddr_wr), 32'(cwr), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("wr_l%0d[%0d] {sel,addr,data}", e.sel, e.addr),
                    32'({csel, caddr_wr, cdata_wr}), 32'(e));
            end
        end
        if (busy)
            busy_cnt++;
        if (busy_prev && !busy) begin
            if (abort_flag)
                abort_flag = 1'b0;
            else
                chk("busy_width", 32'(busy_cnt), 32'(EXP_BUSY));
            busy_cnt = 0;
        end
        busy_prev = busy;
    end

    task automatic fill(input logic [12:0] bg, input int a, input logic [12:0] v);
        for (int i = 0; i < NPIX; i++) img[i] = bg;
        if (a >= 0) img[a] = v;
    endtask

    // Layer0 and layer1 are all zero except at most one word each
    task automatic push_exp(input int a0, input int v0, input int a1, input int v1);
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            e.sel = 1'b0; e.addr = 8'(i); e.data = (i == a0) ? 13'(v0) : 13'd0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < NPOOL; i++) begin
            e.sel = 1'b1; e.addr = 8'(i); e.data = (i == a1) ? 13'(v1) : 13'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic kick(input logic pm);
        @(negedge clk);
        pad_mode = pm;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        pad_mode = ~pm;
        chk("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic run_job(input string tag, input logic pm, input int a0, input int v0, input int a1, input int v1);
        int w0;
        w0 = n_wr;
        push_exp(a0, v0, a1, v1);
        kick(pm);
        for (int k = 0; k < EXP_BUSY + 100 && busy; k++) @(negedge clk);
        chk({tag, "_job_done"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
`ifdef ATCONV_PERF_EN
        chk({tag, "_cycle_cnt"}, cycle_cnt, 32'(EXP_BUSY));
`endif
        job_no++;
        $display("job %0d %s: pad=%0d writes=%0d", job_no, tag, pm, n_wr - w0);
    endtask

    initial begin
        int base;
        int wr_at_abort;
        reset = 1'b0;
        ready = 1'b0;
        pad_mode = 1'b0;
        fill(13'd0, -1, 13'd0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cwr", 32'(cwr), 32'd0);
        chk("rst_crd", 32'(crd), 32'd0);
        chk("rst_csel", 32'(csel), 32'd0);
        chk("rst_iaddr", 32'(iaddr), 32'd0);
        chk("rst_caddr_wr", 32'(caddr_wr), 32'd0);
        chk("rst_caddr_rd", 32'(caddr_rd), 32'd0);
        chk("rst_cdata_wr", 32'(cdata_wr), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        fill(13'd0, 10 * IMG_W + 10, 13'h0100);
        run_job("impulse", 1'b0, 10 * IMG_W + 10, 244, 5 * (IMG_W / 2) + 5, 256);

        fill(13'd0, 0, 13'h0100);
        run_job("corner_rep", 1'b0, 0, 132, 0, 144);
        run_job("corner_zero", 1'b1, 0, 244, 0, 256);

        fill(13'h1000, 10 * IMG_W + 10, 13'h0FFF);
        run_job("saturate", 1'b0, 10 * IMG_W + 10, 4095, 5 * (IMG_W / 2) + 5, 13'h0FF0);

        fill(13'h00A0, -1, 13'd0);
        run_job("constant", 1'b0, -1, 0, -1, 0);

        // Abort during the read phase of pixel 100, then rerun from scratch
        base = n_wr;
        push_exp(-1, 0, -1, 0);
        kick(1'b0);
        for (int k = 0; k < 3000 && (n_wr - base) < 100; k++) @(negedge clk);
        chk("abort_reach_px100", 32'(n_wr - base), 32'd100);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        abort_flag = 1'b1;
        exp_q.delete();
        wr_at_abort = n_wr;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cwr", 32'(cwr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_wr", 32'(n_wr - wr_at_abort), 32'd0);
        job_no++;
        $display("job %0d abort: writes_before_reset=%0d", job_no, wr_at_abort - base);

        run_job("after_abort", 1'b0, -1, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
